// File: rtl/seq_gen_1011.sv
// Serial frame transmitter: preamble, MSB-first payload, then a zero-filled gap.
// Optional macro SEQ_GEN_PARITY_EN appends one even-parity bit after the payload.
module seq_gen_1011 #(
   parameter int         DATA_WIDTH   = 8,
   parameter logic [7:0] PREAMBLE     = 8'b0000_1011,
   parameter int         PREAMBLE_LEN = 4,
   parameter int         IDLE_GAP     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  out_bit,
   output logic                  tx_active,
   output logic                  frame_done
);

   localparam int MAX_A   = (PREAMBLE_LEN > DATA_WIDTH) ? PREAMBLE_LEN : DATA_WIDTH;
   localparam int MAX_CNT = (MAX_A > IDLE_GAP) ? MAX_A : IDLE_GAP;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] PRE_INIT  = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_INIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   // Preamble left-justified so its first bit to send sits in bit 7.
   localparam logic [7:0] PRE_ALIGNED = PREAMBLE << (8 - PREAMBLE_LEN);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
`ifdef SEQ_GEN_PARITY_EN
      PAR,
`endif
      GAP
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [7:0]            r_pre;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_outBit;
   logic                  r_txActive;
   logic                  r_frameDone;
`ifdef SEQ_GEN_PARITY_EN
   logic                  r_parity;
`endif

   assign load_ready = (r_state == IDLE);
   assign out_bit    = r_outBit;
   assign tx_active  = r_txActive;
   assign frame_done = r_frameDone;

   // r_cnt holds how many bits of the current phase remain after the one on out_bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_pre       <= '0;
         r_shift     <= '0;
         r_outBit    <= 1'b0;
         r_txActive  <= 1'b0;
         r_frameDone <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_frameDone <= 1'b0;
         case (r_state)
            IDLE: begin
               r_outBit   <= 1'b0;
               r_txActive <= 1'b0;
               if (load_valid) begin
                  r_state    <= PRE;
                  r_shift    <= load_data;
                  r_pre      <= PRE_ALIGNED << 1;
                  r_cnt      <= PRE_INIT;
                  r_outBit   <= PRE_ALIGNED[7];
                  r_txActive <= 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                  r_parity   <= ^load_data;
`endif
               end
            end
            PRE: begin
               if (r_cnt != '0) begin
                  r_outBit <= r_pre[7];
                  r_pre    <= r_pre << 1;
                  r_cnt    <= r_cnt - CNT_W'(1);
               end else begin
                  r_state  <= DATA;
                  r_outBit <= r_shift[DATA_WIDTH-1];
                  r_shift  <= r_shift << 1;
                  r_cnt    <= DATA_INIT;
               end
            end
            DATA: begin
               if (r_cnt != '0) begin
                  r_outBit <= r_shift[DATA_WIDTH-1];
                  r_shift  <= r_shift << 1;
                  r_cnt    <= r_cnt - CNT_W'(1);
               end else begin
`ifdef SEQ_GEN_PARITY_EN
                  r_state  <= PAR;
                  r_outBit <= r_parity;
`else
                  r_state     <= (IDLE_GAP == 0) ? IDLE : GAP;
                  r_outBit    <= 1'b0;
                  r_txActive  <= 1'b0;
                  r_frameDone <= 1'b1;
                  r_cnt       <= GAP_INIT;
`endif
               end
            end
`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
               r_state     <= (IDLE_GAP == 0) ? IDLE : GAP;
               r_outBit    <= 1'b0;
               r_txActive  <= 1'b0;
               r_frameDone <= 1'b1;
               r_cnt       <= GAP_INIT;
            end
`endif
            GAP: begin
               r_outBit   <= 1'b0;
               r_txActive <= 1'b0;
               if (r_cnt == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state    <= IDLE;
               r_outBit   <= 1'b0;
               r_txActive <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen_1011.sv
// Randomized self-checking bench for seq_gen_1011 against a per-cycle expectation queue.
// Honours SEQ_GEN_PARITY_EN in the reference model when the design is built with it.
module tb_seq_gen_1011;

   localparam int         DATA_WIDTH   = 8;
   localparam logic [7:0] PREAMBLE     = 8'b0000_1011;
   localparam int         PREAMBLE_LEN = 4;
   localparam int         IDLE_GAP     = 2;
   localparam int         NUM_CYCLES   = 4000;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  out_bit;
   logic                  tx_active;
   logic                  frame_done;

   seq_gen_1011 #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PREAMBLE    (PREAMBLE),
      .PREAMBLE_LEN(PREAMBLE_LEN),
      .IDLE_GAP    (IDLE_GAP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_ready(load_ready),
      .out_bit   (out_bit),
      .tx_active (tx_active),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // One entry per future clock cycle describing what the outputs must show.
   typedef struct packed {
      logic bitVal;
      logic txActive;
      logic frameDone;
      logic ready;
   } expCycle_t;

   expCycle_t expQ[$];
   expCycle_t cur;
   int        compareCount  = 0;
   int        mismatchCount = 0;

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, observed, expected);
      end
   endtask

   function automatic expCycle_t currentExpect();
      expCycle_t idleCycle;
      idleCycle = '{bitVal: 1'b0, txActive: 1'b0, frameDone: 1'b0, ready: 1'b1};
      if (expQ.size() != 0) return expQ[0];
      return idleCycle;
   endfunction

   // Whole frame as seen from the cycle after the handshake: preamble, payload, parity, gap.
   task automatic pushFrame(input logic [DATA_WIDTH-1:0] payload);
      logic [7:0] pre;
      pre = PREAMBLE;
      for (int i = PREAMBLE_LEN - 1; i >= 0; i--)
         expQ.push_back('{bitVal: pre[i], txActive: 1'b1, frameDone: 1'b0, ready: 1'b0});
      for (int i = DATA_WIDTH - 1; i >= 0; i--)
         expQ.push_back('{bitVal: payload[i], txActive: 1'b1, frameDone: 1'b0, ready: 1'b0});
`ifdef SEQ_GEN_PARITY_EN
      expQ.push_back('{bitVal: ^payload, txActive: 1'b1, frameDone: 1'b0, ready: 1'b0});
`endif
      if (IDLE_GAP == 0) begin
         expQ.push_back('{bitVal: 1'b0, txActive: 1'b0, frameDone: 1'b1, ready: 1'b1});
      end else begin
         for (int k = 0; k < IDLE_GAP; k++)
            expQ.push_back('{bitVal: 1'b0, txActive: 1'b0, frameDone: (k == 0), ready: 1'b0});
      end
   endtask

   task automatic applyStimulus(input int cycle);
      if (cycle == 0) begin
         reset      = 1'b0;
         load_valid = 1'b1;
         load_data  = 8'hA5;
      end else begin
         reset      = ($urandom_range(0, 149) == 0);
         load_valid = ($urandom_range(0, 3) != 0);
         load_data  = DATA_WIDTH'($urandom);
      end
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      repeat (2) @(posedge clk);

      for (int c = 0; c < NUM_CYCLES; c++) begin
         @(negedge clk);
         cur = currentExpect();
         checkOutput("out_bit",    out_bit,    cur.bitVal);
         checkOutput("tx_active",  tx_active,  cur.txActive);
         checkOutput("frame_done", frame_done, cur.frameDone);
         checkOutput("load_ready", load_ready, cur.ready);
         applyStimulus(c);
         @(posedge clk);
         if (reset) begin
            expQ.delete();
         end else begin
            if (expQ.size() != 0) expQ.delete(0);
            if (cur.ready && load_valid) begin
               expQ.delete();
               pushFrame(load_data);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
